// File: rtl/rom_access_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// State and requester encodings are fixed so waveforms decode the same everywhere.
package rom_access_arbiter_pkg;

   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Requester handshakes plus memory pins for rom_access_arbiter.
// The slave modport is the arbiter; the master modport is the requester/memory side.
interface rom_access_arbiter_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  Req_A;
   logic                  Wr_A;
   logic [ADDR_WIDTH-1:0] Addr_A;
   logic [DATA_WIDTH-1:0] WData_A;
   logic                  Ack_A;
   logic                  RValid_A;

   logic                  Req_B;
   logic                  Wr_B;
   logic [ADDR_WIDTH-1:0] Addr_B;
   logic [DATA_WIDTH-1:0] WData_B;
   logic                  Ack_B;
   logic                  RValid_B;

   logic [DATA_WIDTH-1:0] RData;
   logic                  Busy;

   logic                  Mem_WE;
   logic [ADDR_WIDTH-1:0] Mem_Address;
   logic [DATA_WIDTH-1:0] Mem_Data_In;
   logic [DATA_WIDTH-1:0] Mem_Data_Out;

   modport slave (
      input  Req_A, Wr_A, Addr_A, WData_A,
      input  Req_B, Wr_B, Addr_B, WData_B,
      input  Mem_Data_Out,
      output Ack_A, RValid_A, Ack_B, RValid_B,
      output RData, Busy,
      output Mem_WE, Mem_Address, Mem_Data_In
   );

   modport master (
      output Req_A, Wr_A, Addr_A, WData_A,
      output Req_B, Wr_B, Addr_B, WData_B,
      output Mem_Data_Out,
      input  Ack_A, RValid_A, Ack_B, RValid_B,
      input  RData, Busy,
      input  Mem_WE, Mem_Address, Mem_Data_In
   );

endinterface

// File: rtl/rom_access_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin picker: on a tie the side that did not win last time wins.
module rr_arbiter_2
   import rom_access_arbiter_pkg::*;
(
   input  logic Req_A,
   input  logic Req_B,
   input  logic Last_Grant,
   output logic Grant_Valid,
   output logic Grant_Id
);

   always_comb begin
      Grant_Valid = Req_A | Req_B;
      Grant_Id    = REQ_A;
      if (Req_A && Req_B) begin
         Grant_Id = (Last_Grant == REQ_A) ? REQ_B : REQ_A;
      end else if (Req_B) begin
         Grant_Id = REQ_B;
      end
   end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous memory between requesters A and B, one transaction at a time.
// Writes take IDLE->ISSUE (2 cycles); reads take IDLE->ISSUE->RESP (3 cycles).
module rom_access_arbiter
   import rom_access_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                 Clock,
   input  logic                 Reset,
   rom_access_arbiter_if.slave  bus
);

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_grant_q, last_grant_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   logic                  ack_a_q, ack_a_d;
   logic                  ack_b_q, ack_b_d;
   logic                  rvalid_a_q, rvalid_a_d;
   logic                  rvalid_b_q, rvalid_b_d;
   logic                  busy_q, busy_d;

   logic                  grant_valid;
   logic                  grant_id;

   rr_arbiter_2 u_rr (
      .Req_A       (bus.Req_A),
      .Req_B       (bus.Req_B),
      .Last_Grant  (last_grant_q),
      .Grant_Valid (grant_valid),
      .Grant_Id    (grant_id)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      ack_a_d      = 1'b0;
      ack_b_d      = 1'b0;
      rvalid_a_d   = 1'b0;
      rvalid_b_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               mem_addr_d   = (grant_id == REQ_B) ? bus.Addr_B  : bus.Addr_A;
               mem_din_d    = (grant_id == REQ_B) ? bus.WData_B : bus.WData_A;
               mem_we_d     = (grant_id == REQ_B) ? bus.Wr_B    : bus.Wr_A;
               owner_d      = grant_id;
               last_grant_d = grant_id;
               ack_a_d      = (grant_id == REQ_A);
               ack_b_d      = (grant_id == REQ_B);
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            // The memory acts on the edge leaving ISSUE; read data appears during RESP.
            if (mem_we_q) begin
               state_d = IDLE;
            end else begin
               rvalid_a_d = (owner_q == REQ_A);
               rvalid_b_d = (owner_q == REQ_B);
               state_d    = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= IDLE;
         owner_q      <= REQ_A;
         last_grant_q <= REQ_B;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         ack_a_q      <= 1'b0;
         ack_b_q      <= 1'b0;
         rvalid_a_q   <= 1'b0;
         rvalid_b_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         ack_a_q      <= ack_a_d;
         ack_b_q      <= ack_b_d;
         rvalid_a_q   <= rvalid_a_d;
         rvalid_b_q   <= rvalid_b_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.Mem_WE      = mem_we_q;
   assign bus.Mem_Address = mem_addr_q;
   assign bus.Mem_Data_In = mem_din_q;
   assign bus.Ack_A       = ack_a_q;
   assign bus.Ack_B       = ack_b_q;
   assign bus.RValid_A    = rvalid_a_q;
   assign bus.RValid_B    = rvalid_b_q;
   assign bus.Busy        = busy_q;
   assign bus.RData       = bus.Mem_Data_Out;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter with a 16x8 synchronous memory model behind it.
module tb_rom_access_arbiter;
   import rom_access_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   string tag = "";

   rom_access_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) ifc ();

   rom_access_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   // Memory model: write when WE, otherwise register the addressed word.
   logic [7:0] mem [16];
   logic [7:0] mem_dout;
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem_dout = 8'h00;
   end
   always @(posedge clk) begin
      if (ifc.Mem_WE) mem[ifc.Mem_Address] <= ifc.Mem_Data_In;
      else            mem_dout <= mem[ifc.Mem_Address];
   end
   assign ifc.Mem_Data_Out = mem_dout;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
      end
   endtask

   // Mem_WE may only be high in the ISSUE cycle, which is the cycle Ack is high.
   initial forever begin
      @(negedge clk);
      tests++;
      if (ifc.Mem_WE && !(ifc.Busy && (ifc.Ack_A || ifc.Ack_B) && !ifc.RValid_A && !ifc.RValid_B)) begin
         fails++;
         $display("FAIL mem_we_outside_issue: got Mem_WE=1 Busy=%0b Ack=%0b%0b expected Mem_WE=0",
                  ifc.Busy, ifc.Ack_A, ifc.Ack_B);
      end
   end

   task automatic serve(input bit id, input bit wr, input logic [3:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input bit keep);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         chk("other_ack", id ? ifc.Ack_A : ifc.Ack_B, 0);
         got = id ? ifc.Ack_B : ifc.Ack_A;
      end
      chk(id ? "ack_b_seen" : "ack_a_seen", got, 1);
      if (got) begin
         chk("issue_we", ifc.Mem_WE, wr);
         chk("issue_addr", ifc.Mem_Address, addr);
         if (wr) chk("issue_din", ifc.Mem_Data_In, wd);
         chk("issue_busy", ifc.Busy, 1);
         if (!keep) begin
            if (id) ifc.Req_B = 1'b0;
            else    ifc.Req_A = 1'b0;
         end
         @(negedge clk);
         if (wr) begin
            chk("wr_done_busy", ifc.Busy, 0);
            chk("wr_no_rvalid", {ifc.RValid_A, ifc.RValid_B}, 0);
         end else begin
            chk("rvalid_owner", id ? ifc.RValid_B : ifc.RValid_A, 1);
            chk("rvalid_other", id ? ifc.RValid_A : ifc.RValid_B, 0);
            chk("rdata", ifc.RData, exp_rd);
            @(negedge clk);
            chk("rvalid_width", {ifc.RValid_A, ifc.RValid_B}, 0);
            chk("rd_done_busy", ifc.Busy, 0);
         end
      end
   endtask

   typedef struct {
      bit         ra; bit wa; logic [3:0] aa; logic [7:0] da; logic [7:0] ea;
      bit         rb; bit wb; logic [3:0] ab; logic [7:0] db; logic [7:0] eb;
      bit         first;
   } vec_t;
   vec_t vecs [9];

   initial begin
      vecs[0] = '{1'b1, 1'b1, 4'h2, 8'hAA, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, REQ_A};
      vecs[1] = '{1'b1, 1'b0, 4'h2, 8'h00, 8'hAA, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, REQ_A};
      vecs[2] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00, 8'hAA, REQ_B};
      vecs[3] = '{1'b1, 1'b1, 4'h3, 8'h11, 8'h00, 1'b1, 1'b1, 4'h4, 8'h22, 8'h00, REQ_A};
      vecs[4] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'h11, 1'b1, 1'b0, 4'h4, 8'h00, 8'h22, REQ_A};
      vecs[5] = '{1'b1, 1'b1, 4'hF, 8'h5A, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, REQ_A};
      vecs[6] = '{1'b1, 1'b0, 4'hF, 8'h00, 8'h5A, 1'b1, 1'b1, 4'h0, 8'h33, 8'h00, REQ_B};
      vecs[7] = '{1'b1, 1'b1, 4'h0, 8'h44, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 8'h33, REQ_B};
      vecs[8] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 8'h44, REQ_B};

      rst = 1'b1;
      ifc.Req_A = 1'b0; ifc.Wr_A = 1'b0; ifc.Addr_A = '0; ifc.WData_A = '0;
      ifc.Req_B = 1'b0; ifc.Wr_B = 1'b0; ifc.Addr_B = '0; ifc.WData_B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tag = "reset";
      chk("busy", ifc.Busy, 0);
      chk("mem_we", ifc.Mem_WE, 0);
      chk("mem_addr", ifc.Mem_Address, 0);
      chk("mem_din", ifc.Mem_Data_In, 0);
      chk("acks", {ifc.Ack_A, ifc.Ack_B}, 0);
      chk("rvalids", {ifc.RValid_A, ifc.RValid_B}, 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         tag = $sformatf("vec%0d", i);
         ifc.Req_A = vecs[i].ra; ifc.Wr_A = vecs[i].wa; ifc.Addr_A = vecs[i].aa; ifc.WData_A = vecs[i].da;
         ifc.Req_B = vecs[i].rb; ifc.Wr_B = vecs[i].wb; ifc.Addr_B = vecs[i].ab; ifc.WData_B = vecs[i].db;
         if (vecs[i].first == REQ_A) begin
            serve(REQ_A, vecs[i].wa, vecs[i].aa, vecs[i].da, vecs[i].ea, 1'b0);
            if (vecs[i].rb) serve(REQ_B, vecs[i].wb, vecs[i].ab, vecs[i].db, vecs[i].eb, 1'b0);
         end else begin
            serve(REQ_B, vecs[i].wb, vecs[i].ab, vecs[i].db, vecs[i].eb, 1'b0);
            if (vecs[i].ra) serve(REQ_A, vecs[i].wa, vecs[i].aa, vecs[i].da, vecs[i].ea, 1'b0);
         end
      end

      // Both requesters hold reads continuously: grants must alternate A, B, A, B.
      tag = "alternate";
      ifc.Req_A = 1'b1; ifc.Wr_A = 1'b0; ifc.Addr_A = 4'h3;
      ifc.Req_B = 1'b1; ifc.Wr_B = 1'b0; ifc.Addr_B = 4'h4;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) serve(REQ_A, 1'b0, 4'h3, 8'h00, 8'h11, 1'b1);
         else            serve(REQ_B, 1'b0, 4'h4, 8'h00, 8'h22, 1'b1);
      end
      ifc.Req_A = 1'b0;
      ifc.Req_B = 1'b0;

      // Reset during RESP of a B read.
      tag = "reset_in_resp";
      @(negedge clk);
      ifc.Req_B = 1'b1; ifc.Wr_B = 1'b0; ifc.Addr_B = 4'h4;
      @(negedge clk);
      chk("ack_b", ifc.Ack_B, 1);
      ifc.Req_B = 1'b0;
      @(negedge clk);
      chk("rvalid_b_resp", ifc.RValid_B, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("busy", ifc.Busy, 0);
      chk("rvalid_b", ifc.RValid_B, 0);
      chk("mem_we", ifc.Mem_WE, 0);
      chk("ack_b_after", ifc.Ack_B, 0);
      rst = 1'b0;
      ifc.Req_A = 1'b1; ifc.Wr_A = 1'b0; ifc.Addr_A = 4'h3;
      ifc.Req_B = 1'b1; ifc.Wr_B = 1'b0; ifc.Addr_B = 4'h4;
      serve(REQ_A, 1'b0, 4'h3, 8'h00, 8'h11, 1'b0);
      serve(REQ_B, 1'b0, 4'h4, 8'h00, 8'h22, 1'b0);

      // Req_B raised while A's write is in ISSUE must wait for IDLE.
      tag = "req_b_in_issue";
      ifc.Req_A = 1'b1; ifc.Wr_A = 1'b1; ifc.Addr_A = 4'h6; ifc.WData_A = 8'h66;
      @(negedge clk);
      chk("ack_a", ifc.Ack_A, 1);
      ifc.Req_A = 1'b0;
      ifc.Req_B = 1'b1; ifc.Wr_B = 1'b0; ifc.Addr_B = 4'h6;
      @(negedge clk);
      chk("ack_b_early", ifc.Ack_B, 0);
      chk("idle_busy", ifc.Busy, 0);
      serve(REQ_B, 1'b0, 4'h6, 8'h00, 8'h66, 1'b0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish expected finish before 50000");
      $fatal(1, "timeout");
   end

endmodule
